// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/execute/writeback,
// stalls on mem_ready, traps illegal opcodes and memory timeouts into a
// sticky FAULT state, and counts retired instructions.
module multicycle_control #(
  parameter int unsigned     OPW      = 6,
  parameter logic [OPW-1:0]  OP_RTYPE = 6'h00,
  parameter logic [OPW-1:0]  OP_LW    = 6'h23,
  parameter logic [OPW-1:0]  OP_SW    = 6'h2B,
  parameter logic [OPW-1:0]  OP_BEQ   = 6'h04,
  parameter logic [OPW-1:0]  OP_J     = 6'h02,
  parameter logic [OPW-1:0]  OP_ADDI  = 6'h08,
  parameter int unsigned     MAX_WAIT = 15,
  parameter int unsigned     RETW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            instr_done,
  output logic [RETW-1:0] retire_count,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [3:0]      state
);

  localparam int unsigned           WAITW      = $clog2(MAX_WAIT + 1);
  localparam logic [WAITW-1:0]      WAIT_LIMIT = WAITW'(MAX_WAIT);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_FAULT  = 4'd13
  } state_e;

  state_e            state_q, state_d;
  logic [WAITW-1:0]  wait_q, wait_d;
  logic [WAITW-1:0]  wait_inc;
  logic [RETW-1:0]   retire_q, retire_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic              is_mem_state;

  // State, wait counter, retire counter and fault code registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge values; blocking would make results depend on statement order.
    if (rst) begin
      state_q      <= S_RESET;
      wait_q       <= '0;
      retire_q     <= '0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      retire_q     <= retire_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next-state sequencing, memory-wait tracking and fault trapping.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    wait_d       = '0;
    fault_code_d = fault_code_q;
    wait_inc     = wait_q + 1'b1;
    is_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);

    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d      = S_FAULT;
            fault_code_d = 2'b01;
          end
        endcase
      end
      // The IR holds the opcode stable, so it still selects load vs store.
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase

    // A stalled memory access either keeps counting or times out.
    if (is_mem_state && !mem_ready) begin
      if (wait_inc == WAIT_LIMIT) begin
        state_d      = S_FAULT;
        fault_code_d = 2'b10;
      end else begin
        wait_d = wait_inc;
      end
    end
  end

  // Moore decode of control outputs; only FETCH and MEMWR look at mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Retire counter advances on every final instruction cycle, wrapping.
  always_comb begin
    retire_d = retire_q + RETW'(instr_done);
  end

  assign fault        = (state_q == S_FAULT);
  assign fault_code   = fault_code_q;
  assign retire_count = retire_q;
  assign state        = state_q;

endmodule
